seg_scan_capture: RTL and testbench

//  Monitors an anode-multiplexed, active-low 7-segment display bus and reconstructs the digit values being shown.

---
 rtl/seg_pkg.sv | 26 ++
 rtl/segment_to_code.sv | 34 +++
 rtl/seg_scan_capture.sv | 172 +++++++++++++++++
 tb/tb_seg_scan_capture.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment scan capture block.
// Glyphs are active-low cathode patterns, bit6..bit0 = g..a.
package seg_pkg;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_F = 7'b0001110;

    localparam logic [3:0] CODE_F   = 4'hF;
    localparam logic [3:0] CODE_BAD = 4'hE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/segment_to_code.sv
// Combinational decode of an active-low segment pattern back to its digit code.
// Unrecognised patterns yield CODE_BAD with err set.
module segment_to_code
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       err
);

    // Table lookup from glyph to code; everything else is flagged as bad.
    always_comb begin
        code = CODE_BAD;
        err  = 1'b0;
        case (seg)
            SEG_0:   code = 4'h0;
            SEG_1:   code = 4'h1;
            SEG_2:   code = 4'h2;
            SEG_3:   code = 4'h3;
            SEG_4:   code = 4'h4;
            SEG_5:   code = 4'h5;
            SEG_6:   code = 4'h6;
            SEG_7:   code = 4'h7;
            SEG_8:   code = 4'h8;
            SEG_9:   code = 4'h9;
            SEG_F:   code = CODE_F;
            default: begin
                code = CODE_BAD;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Watches a multiplexed active-low 7-segment bus, samples each digit once it
// has been stable for SETTLE_CYCLES, and assembles a frame of digit codes
// delivered on a valid/ready handshake. Frames that complete while the
// previous one is still pending are dropped and flagged with overrun.
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              seg,
    output logic [4*NUM_DIGITS-1:0] frame_digits,
    output logic [NUM_DIGITS-1:0]   frame_err,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    overrun
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);

    // Synchroniser and previous-sample registers (blank = all ones).
    logic [NUM_DIGITS-1:0]       an_m_q, an_s_q;
    logic [6:0]                  seg_m_q, seg_s_q;
    logic [NUM_DIGITS+6:0]       prev_q, prev_d;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0][3:0]  slot_code_q, slot_code_d;
    logic [NUM_DIGITS-1:0]       slot_err_q, slot_err_d;
    logic [NUM_DIGITS-1:0]       mask_q, mask_d;
    logic [4*NUM_DIGITS-1:0]     frame_digits_q, frame_digits_d;
    logic [NUM_DIGITS-1:0]       frame_err_q, frame_err_d;
    logic                        frame_valid_q, frame_valid_d;
    logic                        overrun_q, overrun_d;

    logic [NUM_DIGITS-1:0]       an_lo;
    logic                        sel_valid;
    logic [IDX_W-1:0]            idx;
    logic                        changed;
    logic                        capture;
    logic                        mask_full;
    logic                        load;
    logic [3:0]                  dec_code;
    logic                        dec_err;

    segment_to_code u_dec (
        .seg  (seg_s_q),
        .code (dec_code),
        .err  (dec_err)
    );

    // Digit select is legal only with exactly one anode low; idx is its position.
    always_comb begin
        an_lo     = ~an_s_q;
        sel_valid = (an_lo != '0) && ((an_lo & (an_lo - NUM_DIGITS'(1))) == '0);
        idx       = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_lo[i]) idx = IDX_W'(i);
        end
        prev_d  = {an_s_q, seg_s_q};
        changed = (prev_d != prev_q);
    end

    // Dwell tracking: one capture per stable dwell, counter saturates at the capture point.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (changed) begin
                    cnt_d   = '0;
                    state_d = sel_valid ? SETTLE : IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (changed) begin
                    cnt_d   = '0;
                    state_d = sel_valid ? SETTLE : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Slot update, frame assembly and output handshake.
    always_comb begin
        slot_code_d    = slot_code_q;
        slot_err_d     = slot_err_q;
        mask_d         = mask_q;
        frame_digits_d = frame_digits_q;
        frame_err_d    = frame_err_q;
        frame_valid_d  = frame_valid_q;

        mask_full = &mask_q;
        load      = mask_full && (!frame_valid_q || frame_ready);
        overrun_d = mask_full && !load;

        if (frame_valid_q && frame_ready) frame_valid_d = 1'b0;
        if (load) begin
            frame_digits_d = slot_code_q;
            frame_err_d    = slot_err_q;
            frame_valid_d  = 1'b1;
        end
        if (mask_full) mask_d = '0;
        if (capture) begin
            slot_code_d[idx] = dec_code;
            slot_err_d[idx]  = dec_err;
            mask_d[idx]      = 1'b1;
        end
    end

    // All state registers; asynchronous reset returns the block to a blank, empty state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_m_q         <= '1;
            an_s_q         <= '1;
            seg_m_q        <= '1;
            seg_s_q        <= '1;
            prev_q         <= '1;
            state_q        <= IDLE;
            cnt_q          <= '0;
            slot_code_q    <= '0;
            slot_err_q     <= '0;
            mask_q         <= '0;
            frame_digits_q <= '0;
            frame_err_q    <= '0;
            frame_valid_q  <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            an_m_q         <= an;
            an_s_q         <= an_m_q;
            seg_m_q        <= seg;
            seg_s_q        <= seg_m_q;
            prev_q         <= prev_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            slot_code_q    <= slot_code_d;
            slot_err_q     <= slot_err_d;
            mask_q         <= mask_d;
            frame_digits_q <= frame_digits_d;
            frame_err_q    <= frame_err_d;
            frame_valid_q  <= frame_valid_d;
            overrun_q      <= overrun_d;
        end
    end

    assign frame_digits = frame_digits_q;
    assign frame_err    = frame_err_q;
    assign frame_valid  = frame_valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: scans, glitches, bad glyphs,
// backpressure, illegal selects and asynchronous reset mid-dwell.
module tb_seg_scan_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  an = 4'hF;
    logic [6:0]  seg = 7'h7F;
    logic [15:0] frame_digits;
    logic [3:0]  frame_err;
    logic        frame_valid;
    logic        frame_ready = 1'b0;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;

    int          hs_cnt = 0;
    int          ovr_cnt = 0;
    logic [15:0] last_digits = '0;
    logic [3:0]  last_err = '0;

    seg_scan_capture #(
        .NUM_DIGITS    (4),
        .SETTLE_CYCLES (16),
        .CNT_W         (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .an           (an),
        .seg          (seg),
        .frame_digits (frame_digits),
        .frame_err    (frame_err),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Record every accepted frame and every overrun pulse.
    always @(posedge clk) begin
        if (rst_n && frame_valid && frame_ready) begin
            hs_cnt      <= hs_cnt + 1;
            last_digits <= frame_digits;
            last_err    <= frame_err;
        end
        if (rst_n && overrun) ovr_cnt <= ovr_cnt + 1;
    end

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0:       glyph = 7'b1000000;
            1:       glyph = 7'b1111001;
            2:       glyph = 7'b0100100;
            3:       glyph = 7'b0110000;
            4:       glyph = 7'b0011001;
            5:       glyph = 7'b0010010;
            6:       glyph = 7'b0000010;
            7:       glyph = 7'b1111000;
            8:       glyph = 7'b0000000;
            9:       glyph = 7'b0010000;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    task automatic do_reset();
        rst_n       = 1'b0;
        an          = 4'hF;
        seg         = 7'h7F;
        frame_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic dwell(input int d, input logic [6:0] s, input int cycles);
        an    = 4'hF;
        an[d] = 1'b0;
        seg   = s;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic blank(input int cycles);
        an  = 4'hF;
        seg = 7'h7F;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3);
        dwell(0, s0, 40);
        dwell(1, s1, 40);
        dwell(2, s2, 40);
        dwell(3, s3, 40);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", frame_valid); end
        n_checks++;
        if (frame_digits !== 16'h0) begin n_fail++; $display("FAIL reset_digits: got %h want 0000", frame_digits); end
        n_checks++;
        if (frame_err !== 4'h0) begin n_fail++; $display("FAIL reset_err: got %b want 0000", frame_err); end
        n_checks++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        n_checks++;
        if (dut.state_q !== seg_pkg::IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
    endtask

    task automatic test_scan();
        int h0, o0;
        do_reset();
        frame_ready = 1'b1;
        h0 = hs_cnt;
        o0 = ovr_cnt;
        scan(glyph(3), glyph(0), glyph(1), glyph(1));
        n_checks++;
        if (hs_cnt - h0 !== 1) begin n_fail++; $display("FAIL scan_frames_pass1: got %0d want 1", hs_cnt - h0); end
        n_checks++;
        if (last_digits !== 16'h1103) begin n_fail++; $display("FAIL scan_digits: got %h want 1103", last_digits); end
        n_checks++;
        if (last_err !== 4'h0) begin n_fail++; $display("FAIL scan_err: got %b want 0000", last_err); end
        scan(glyph(3), glyph(0), glyph(1), glyph(1));
        blank(5);
        n_checks++;
        if (hs_cnt - h0 !== 2) begin n_fail++; $display("FAIL scan_frames_pass2: got %0d want 2", hs_cnt - h0); end
        n_checks++;
        if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL scan_valid_after: got %b want 0", frame_valid); end
        n_checks++;
        if (ovr_cnt - o0 !== 0) begin n_fail++; $display("FAIL scan_overrun: got %0d want 0", ovr_cnt - o0); end
    endtask

    task automatic test_glitch();
        int h0;
        do_reset();
        frame_ready = 1'b1;
        h0 = hs_cnt;
        dwell(0, glyph(4), 40);
        dwell(1, glyph(5), 40);
        dwell(2, glyph(2), 10);
        n_checks++;
        if (dut.mask_q !== 4'b0011) begin n_fail++; $display("FAIL glitch_no_capture: got mask %b want 0011", dut.mask_q); end
        dwell(2, glyph(7), 40);
        n_checks++;
        if (dut.mask_q !== 4'b0111) begin n_fail++; $display("FAIL glitch_capture: got mask %b want 0111", dut.mask_q); end
        dwell(3, glyph(9), 40);
        n_checks++;
        if (last_digits !== 16'h9754) begin n_fail++; $display("FAIL glitch_digits: got %h want 9754", last_digits); end
        n_checks++;
        if (hs_cnt - h0 !== 1) begin n_fail++; $display("FAIL glitch_frames: got %0d want 1", hs_cnt - h0); end
    endtask

    task automatic test_bad_glyph();
        int h0;
        do_reset();
        frame_ready = 1'b1;
        h0 = hs_cnt;
        scan(7'b1111111, 7'b0001110, glyph(8), glyph(6));
        n_checks++;
        if (hs_cnt - h0 !== 1) begin n_fail++; $display("FAIL bad_frames: got %0d want 1", hs_cnt - h0); end
        n_checks++;
        if (last_digits !== 16'h68FE) begin n_fail++; $display("FAIL bad_digits: got %h want 68fe", last_digits); end
        n_checks++;
        if (last_err !== 4'b0001) begin n_fail++; $display("FAIL bad_err: got %b want 0001", last_err); end
    endtask

    task automatic test_backpressure();
        int h0, o0;
        do_reset();
        frame_ready = 1'b0;
        h0 = hs_cnt;
        o0 = ovr_cnt;
        scan(glyph(1), glyph(2), glyph(3), glyph(4));
        n_checks++;
        if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid1: got %b want 1", frame_valid); end
        n_checks++;
        if (frame_digits !== 16'h4321) begin n_fail++; $display("FAIL bp_digits1: got %h want 4321", frame_digits); end
        n_checks++;
        if (ovr_cnt - o0 !== 0) begin n_fail++; $display("FAIL bp_overrun1: got %0d want 0", ovr_cnt - o0); end
        scan(glyph(5), glyph(6), glyph(7), glyph(8));
        blank(5);
        n_checks++;
        if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid2: got %b want 1", frame_valid); end
        n_checks++;
        if (frame_digits !== 16'h4321) begin n_fail++; $display("FAIL bp_digits_held: got %h want 4321", frame_digits); end
        n_checks++;
        if (frame_err !== 4'h0) begin n_fail++; $display("FAIL bp_err: got %b want 0000", frame_err); end
        n_checks++;
        if (ovr_cnt - o0 !== 1) begin n_fail++; $display("FAIL bp_overrun_once: got %0d want 1", ovr_cnt - o0); end
        frame_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b want 0", frame_valid); end
        n_checks++;
        if (hs_cnt - h0 !== 1) begin n_fail++; $display("FAIL bp_handshakes: got %0d want 1", hs_cnt - h0); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_new_frame: got %b want 0", frame_valid); end
    endtask

    task automatic test_illegal_select();
        do_reset();
        frame_ready = 1'b1;
        an  = 4'b1100;
        seg = glyph(3);
        repeat (50) @(negedge clk);
        n_checks++;
        if (dut.state_q !== seg_pkg::IDLE) begin n_fail++; $display("FAIL illegal_two_state: got %0d want IDLE", dut.state_q); end
        n_checks++;
        if (dut.mask_q !== 4'h0) begin n_fail++; $display("FAIL illegal_two_mask: got %b want 0000", dut.mask_q); end
        an = 4'b1111;
        repeat (50) @(negedge clk);
        n_checks++;
        if (dut.state_q !== seg_pkg::IDLE) begin n_fail++; $display("FAIL illegal_none_state: got %0d want IDLE", dut.state_q); end
        n_checks++;
        if (dut.slot_code_q !== 16'h0) begin n_fail++; $display("FAIL illegal_slots: got %h want 0000", dut.slot_code_q); end
        n_checks++;
        if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_valid: got %b want 0", frame_valid); end
    endtask

    task automatic test_reset_mid_dwell();
        int h0;
        do_reset();
        frame_ready = 1'b0;
        scan(glyph(2), glyph(4), glyph(6), glyph(8));
        n_checks++;
        if (frame_digits !== 16'h8642) begin n_fail++; $display("FAIL rst_pre_digits: got %h want 8642", frame_digits); end
        dwell(1, glyph(3), 11);
        n_checks++;
        if (dut.state_q !== seg_pkg::SETTLE || dut.cnt_q !== 5'd8) begin
            n_fail++;
            $display("FAIL rst_pre_settle: got state %0d cnt %0d want SETTLE cnt 8", dut.state_q, dut.cnt_q);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b want 0", frame_valid); end
        n_checks++;
        if (frame_digits !== 16'h0) begin n_fail++; $display("FAIL rst_async_digits: got %h want 0000", frame_digits); end
        n_checks++;
        if (dut.state_q !== seg_pkg::IDLE || dut.cnt_q !== 5'd0) begin
            n_fail++;
            $display("FAIL rst_async_fsm: got state %0d cnt %0d want IDLE cnt 0", dut.state_q, dut.cnt_q);
        end
        n_checks++;
        if (dut.mask_q !== 4'h0) begin n_fail++; $display("FAIL rst_async_mask: got %b want 0000", dut.mask_q); end
        an = 4'hF;
        seg = 7'h7F;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        frame_ready = 1'b1;
        repeat (2) @(negedge clk);
        h0 = hs_cnt;
        scan(glyph(9), glyph(8), glyph(7), glyph(6));
        n_checks++;
        if (hs_cnt - h0 !== 1) begin n_fail++; $display("FAIL rst_after_frames: got %0d want 1", hs_cnt - h0); end
        n_checks++;
        if (last_digits !== 16'h6789) begin n_fail++; $display("FAIL rst_after_digits: got %h want 6789", last_digits); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_glitch();
        test_bad_glyph();
        test_backpressure();
        test_illegal_select();
        test_reset_mid_dwell();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
